mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: validates a load/store request, sequences the DM
// read / read-modify-write, and returns the extended load result with a done pulse.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        done,
    output logic [31:0] rd_data,
    output logic [1:0]  exc,
    output logic [11:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_we,
    output logic [31:0] m_pc,
    input  logic [31:0] m_rdata
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {IDLE, ACC, WR} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [13:0] addr_q;
    logic [31:0] wdata_q, pc_q, merge_q;
    logic        accept, addr_err;
    logic [4:0]  shamt;
    logic [15:0] lane_data;
    logic [31:0] lane_mask, load_val, merge_val;

    always_comb begin
        addr_err = 1'b0;
        case (op)
            OP_LW, OP_SW:         if (addr[1:0] != 2'b00) addr_err = 1'b1;
            OP_LH, OP_LHU, OP_SH: if (addr[0]) addr_err = 1'b1;
            default: ;
        endcase
        if (addr[31:14] != '0) addr_err = 1'b1;
        if ({20'd0, addr[13:2]} >= 32'(MEM_WORDS)) addr_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // m_we is gated by reset directly so a write in flight is killed in the reset cycle
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        m_addr    = '0;
        m_pc      = '0;
        m_we      = 1'b0;
        m_wdata   = '0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset && !addr_err) state_nxt = ACC;
            end
            ACC: begin
                m_addr = addr_q[13:2];
                m_pc   = pc_q;
                if (op_q == OP_SW) begin
                    m_we      = !reset;
                    m_wdata   = wdata_q;
                    state_nxt = IDLE;
                end else if (op_q == OP_SH || op_q == OP_SB) begin
                    state_nxt = WR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                m_addr    = addr_q[13:2];
                m_pc      = pc_q;
                m_we      = !reset;
                m_wdata   = merge_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = req_ready && req_valid;

    always_comb begin
        shamt     = {addr_q[1:0], 3'b000};
        lane_data = 16'(m_rdata >> shamt);
        case (op_q)
            OP_LW:   load_val = m_rdata;
            OP_LH:   load_val = {{16{lane_data[15]}}, lane_data};
            OP_LHU:  load_val = {16'd0, lane_data};
            OP_LB:   load_val = {{24{lane_data[7]}}, lane_data[7:0]};
            OP_LBU:  load_val = {24'd0, lane_data[7:0]};
            default: load_val = '0;
        endcase
        lane_mask = ((op_q == OP_SH) ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
        merge_val = (m_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            merge_q <= '0;
            done    <= 1'b0;
            exc     <= '0;
            rd_data <= '0;
        end else begin
            done    <= 1'b0;
            exc     <= '0;
            rd_data <= '0;
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr[13:0];
                wdata_q <= wdata;
                pc_q    <= pc;
                if (addr_err) begin
                    done <= 1'b1;
                    exc  <= (op <= OP_LBU) ? 2'd1 : 2'd2;
                end
            end
            if (state == ACC) begin
                if (op_q <= OP_LBU) begin
                    rd_data <= load_val;
                    done    <= 1'b1;
                end else if (op_q == OP_SW) begin
                    done <= 1'b1;
                end else begin
                    merge_q <= merge_val;
                end
            end
            if (state == WR) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized requests checked against
// a behavioural memory/access model.
module tb_mem_access_ctrl;

    localparam int MEM_WORDS = 3072;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                           SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, done, m_we;
    logic [2:0]  op;
    logic [31:0] addr, wdata, pc, rd_data, m_wdata, m_pc, m_rdata;
    logic [1:0]  exc;
    logic [11:0] m_addr;

    logic [31:0] dm [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .addr(addr), .wdata(wdata), .pc(pc), .done(done), .rd_data(rd_data),
        .exc(exc), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_pc(m_pc),
        .m_rdata(m_rdata)
    );

    assign m_rdata = (int'(m_addr) < MEM_WORDS) ? dm[m_addr] : 32'd0;

    always @(posedge clk) begin
        if (m_we) dm[m_addr] <= m_wdata;
        else if (pre_we) dm[pre_addr] <= pre_data;
    end

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic addr_err_m(input logic [2:0] o, input logic [31:0] a);
        int align;
        align = (o == LW || o == SW) ? 4 : (o == LH || o == LHU || o == SH) ? 2 : 1;
        return (a % align != 0) || (a >= 32'h4000) || ((a >> 2) >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] load_m(input logic [2:0] o, input logic [31:0] word,
                                           input logic [1:0] lane);
        logic [31:0] v;
        int          val;
        v = word >> (8 * lane);
        case (o)
            LH:  begin val = int'(v & 32'hFFFF); if (val >= 32768) val -= 65536; end
            LHU: val = int'(v & 32'hFFFF);
            LB:  begin val = int'(v & 32'hFF); if (val >= 128) val -= 256; end
            LBU: val = int'(v & 32'hFF);
            default: val = int'(word);
        endcase
        return val;
    endfunction

    function automatic logic [31:0] store_m(input logic [2:0] o, input logic [31:0] word,
                                            input logic [31:0] wd, input logic [1:0] lane);
        logic [31:0] mask;
        if (o == SW) return wd;
        mask = ((o == SH) ? 32'hFFFF : 32'hFF) << (8 * lane);
        return (word & ~mask) | ((wd << (8 * lane)) & mask);
    endfunction

    task automatic poke(input int w, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = 12'(w); pre_data = d;
        ref_mem[w] = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] p, output logic [31:0] got_rd);
        logic        err, ld;
        int          lat_exp, lat_seen, n_done, n_we, w, t;
        logic [31:0] exp_rd, exp_w;
        ld = (o <= LBU);
        err = addr_err_m(o, a);
        w = int'(a[13:2]);
        lat_exp = err ? 1 : ((o == SH || o == SB) ? 3 : 2);
        exp_rd = '0;
        exp_w = '0;
        if (!err && ld) exp_rd = load_m(o, ref_mem[w], a[1:0]);
        if (!err && !ld) exp_w = store_m(o, ref_mem[w], wd, a[1:0]);
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 10) begin @(negedge clk); t++; end
        chk("ready_wait", {31'd0, req_ready}, 1);
        op = o; addr = a; wdata = wd; pc = p; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat_seen = 0; n_done = 0; n_we = 0; got_rd = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("ready_after_accept", {31'd0, req_ready}, {31'd0, err});
                chk("m_addr", {20'd0, m_addr}, err ? 32'd0 : {20'd0, a[13:2]});
                chk("m_pc", m_pc, err ? 32'd0 : p);
            end
            if (m_we) begin
                n_we++;
                chk("we_cycle", k, lat_exp - 1);
                chk("w_addr", {20'd0, m_addr}, {20'd0, a[13:2]});
                chk("w_data", m_wdata, exp_w);
            end
            if (done) begin
                n_done++;
                if (lat_seen == 0) lat_seen = k;
                got_rd = rd_data;
                chk("exc", {30'd0, exc}, err ? (ld ? 32'd1 : 32'd2) : 32'd0);
                if (ld || err) chk("rd_data", rd_data, exp_rd);
            end
        end
        chk("latency", lat_seen, lat_exp);
        chk("done_pulses", n_done, 1);
        chk("we_pulses", n_we, (!err && !ld) ? 1 : 0);
        if (!err && !ld) begin
            ref_mem[w] = exp_w;
            chk("dm_word", dm[w], exp_w);
        end
    endtask

    initial begin
        logic [31:0] r, a;
        logic [2:0]  o;
        int          mode, lane, c0;

        reset = 1'b1; req_valid = 1'b0; op = '0; addr = '0; wdata = '0; pc = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 0);
        chk("rst_we", {31'd0, m_we}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_exc", {30'd0, exc}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_m_addr", {20'd0, m_addr}, 0);
        chk("rst_m_pc", m_pc, 0);
        chk("idle_ready", {31'd0, req_ready}, 1);

        for (int i = 0; i < 64; i++) poke(i, $urandom);
        poke(3071, $urandom);

        poke(50, 32'd0);
        do_req(SW, 32'h0000_00C8, 32'd50, 32'h0000_1000, r);
        chk("sw50_mem", dm[50], 32'd50);

        poke(50, 32'h8899_AABB);
        do_req(LB, 32'h0000_00C9, 32'd0, 32'h0000_1004, r);
        chk("lb_c9", r, 32'hFFFF_FFAA);
        do_req(LBU, 32'h0000_00C9, 32'd0, 32'h0000_1008, r);
        chk("lbu_c9", r, 32'h0000_00AA);
        do_req(LH, 32'h0000_00CA, 32'd0, 32'h0000_100C, r);
        chk("lh_ca", r, 32'hFFFF_8899);
        do_req(SB, 32'h0000_00CB, 32'h0000_0012, 32'h0000_1010, r);
        chk("sb_cb_mem", dm[50], 32'h1299_AABB);

        do_req(LW, 32'h0000_2FFC, 32'd0, 32'h0000_1014, r);
        chk("lw_last_word", r, ref_mem[3071]);
        do_req(LW, 32'h0000_3000, 32'd0, 32'h0000_1018, r);
        do_req(SH, 32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_101C, r);

        for (int n = 0; n < 80; n++) begin
            o = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 9);
            lane = $urandom_range(0, 3);
            if (o == LW || o == SW) lane = 0;
            if (o == LH || o == LHU || o == SH) lane = lane & 2;
            if (mode <= 6)      a = $urandom_range(0, 63) * 4 + lane;
            else if (mode == 7) a = $urandom_range(0, 63) * 4 + $urandom_range(1, 3);
            else if (mode == 8) a = (3071 + $urandom_range(0, 3)) * 4 + lane;
            else                a = $urandom_range(0, 255) | ($urandom_range(1, 32'h3FFFF) << 14);
            do_req(o, a, $urandom, $urandom, r);
        end

        // reset while the sb write-back is pending must leave the word untouched
        poke(10, 32'hA5A5_5A5A);
        c0 = done_cnt;
        @(negedge clk);
        op = SB; addr = 32'd41; wdata = 32'h0000_0077; pc = 32'h0000_2000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("wr_rst_we", {31'd0, m_we}, 0);
        chk("wr_rst_ready", {31'd0, req_ready}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 1);
        chk("post_rst_done", {31'd0, done}, 0);
        repeat (3) @(negedge clk);
        chk("wr_rst_mem", dm[10], 32'hA5A5_5A5A);
        chk("wr_rst_no_done", done_cnt - c0, 0);

        c0 = done_cnt;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            op = LW; addr = 32'((i + 5) * 4); pc = 32'(32'h3000 + i * 4); req_valid = 1'b1;
            chk("b2b_ready", {31'd0, req_ready}, 1);
            @(negedge clk);
            chk("b2b_acc_ready", {31'd0, req_ready}, 0);
            chk("b2b_acc_done", {31'd0, done}, 0);
            @(negedge clk);
            chk("b2b_done", {31'd0, done}, 1);
            chk("b2b_rd_data", rd_data, ref_mem[i + 5]);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_pulses", done_cnt - c0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
